// File: rtl/split_track_pkg.sv
// split_track_pkg: shared definitions for the address-decoded splitter.
//   state_t      - splitter FSM states (IDLE/BUSY/ERR, fixed encodings)
//   req_width()  - packed request width  {valid, addr, wdata, wstrb}
//   resp_width() - packed response width {rdata, ready}
package split_track_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/split_decode.sv
// split_decode: combinational address-to-slave decode.
//   addr_msb in  NB  top NB bits of the request address
//   sel      out NB  selected slave index
//   mapped   out 1   high when sel names an existing slave (sel < N_SLAVES)
module split_decode #(
  parameter int N_SLAVES = 2,
  parameter int NB       = 1
) (
  input  logic [NB-1:0] addr_msb,
  output logic [NB-1:0] sel,
  output logic          mapped
);

  always_comb begin
    sel    = addr_msb;
    mapped = (32'(addr_msb) < 32'(N_SLAVES));
  end

endmodule

// File: rtl/split_track.sv
// split_track: 1-to-N splitter on the native valid/ready bus with
// single-outstanding-transaction tracking.
//   clk    in  1                 clock
//   rst    in  1                 asynchronous active-low reset
//   m_req  in  REQ_W             master request {valid, addr, wdata, wstrb}
//   m_resp out RESP_W            master response {rdata, ready}
//   s_req  out N_SLAVES*REQ_W    slave requests, slot k at [k*REQ_W +: REQ_W]
//   s_resp in  N_SLAVES*RESP_W   slave responses, slot k at [k*RESP_W +: RESP_W]
//   err    out 1                 registered pulse on unmapped access or timeout
// Optional: define SPLIT_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT cycles.
module split_track
  import split_track_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NB       = $clog2(N_SLAVES) + (($clog2(N_SLAVES) == 0) ? 1 : 0),
  parameter int TIMEOUT  = 255,
  localparam int REQ_W   = req_width(ADDR_W, DATA_W),
  localparam int RESP_W  = resp_width(DATA_W)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_W-1:0]             m_req,
  output logic [RESP_W-1:0]            m_resp,
  output logic [N_SLAVES*REQ_W-1:0]    s_req,
  input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
  output logic                         err
);

  state_t            state, state_d;
  logic [NB-1:0]     sel_reg, sel_d;
  logic [NB-1:0]     dec_sel, route_sel;
  logic              dec_mapped;
  logic              m_valid;
  logic              err_d;
  logic              route_en;
  logic              slot_ready;
  logic [RESP_W-1:0] slot_resp;
  logic [REQ_W-1:0]  fwd_req;

`ifdef SPLIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_d;
`endif

  assign m_valid = m_req[REQ_W-1];

  split_decode #(
    .N_SLAVES (N_SLAVES),
    .NB       (NB)
  ) u_decode (
    .addr_msb (m_req[REQ_W-2 -: NB]),
    .sel      (dec_sel),
    .mapped   (dec_mapped)
  );

  always_comb begin
    state_d  = state;
    sel_d    = sel_reg;
    err_d    = 1'b0;
    s_req    = '0;
    m_resp   = '0;
    fwd_req  = m_req;
    route_en = 1'b0;
`ifdef SPLIT_TIMEOUT_EN
    cnt_d    = cnt;
`endif

    // While BUSY the captured slave owns the bus regardless of the live address.
    route_sel = (state == BUSY) ? sel_reg : dec_sel;
    slot_resp = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (k == 32'(route_sel)) slot_resp = s_resp[k*RESP_W +: RESP_W];
    end
    slot_ready = slot_resp[0];

    // Outputs are held at zero for as long as reset is asserted.
    if (rst) begin
      case (state)
        IDLE: begin
          if (m_valid) begin
            if (dec_mapped) begin
              route_en = 1'b1;
              m_resp   = slot_resp;
              sel_d    = dec_sel;
              if (!slot_ready) begin
                state_d = BUSY;
`ifdef SPLIT_TIMEOUT_EN
                cnt_d   = '0;
`endif
              end
            end else begin
              err_d   = 1'b1;
              state_d = ERR;
            end
          end
        end
        BUSY: begin
          route_en = 1'b1;
          m_resp   = slot_resp;
          if (slot_ready) state_d = IDLE;
`ifdef SPLIT_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT)) begin
            fwd_req[REQ_W-1] = 1'b0;
            m_resp           = RESP_W'(1);
            err_d            = 1'b1;
            state_d          = IDLE;
          end else begin
            cnt_d = cnt + 1'b1;
          end
`endif
        end
        ERR: begin
          m_resp  = RESP_W'(1);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (route_en) begin
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
          if (k == 32'(route_sel)) s_req[k*REQ_W +: REQ_W] = fwd_req;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sel_reg <= '0;
      err     <= 1'b0;
`ifdef SPLIT_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_d;
      sel_reg <= sel_d;
      err     <= err_d;
`ifdef SPLIT_TIMEOUT_EN
      cnt     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_split_track.sv
// tb_split_track: directed bench for split_track (3 slaves, TIMEOUT=4).
// A transaction-level model predicts s_req/m_resp/err every cycle; directed
// steps add hand-computed literal checks. Honors SPLIT_TIMEOUT_EN.
module tb_split_track;

  localparam int N      = 3;
  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;
  localparam int TMO    = 4;
`ifdef SPLIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [REQ_W-1:0]      m_req;
  logic [RESP_W-1:0]     m_resp;
  logic [N*REQ_W-1:0]    s_req;
  logic [N*RESP_W-1:0]   s_resp;
  logic                  err;
  logic [31:0]           srd  [3];
  logic                  srdy [3];

  int n_cmp  = 0;
  int n_fail = 0;

  assign s_resp = {srd[2], srdy[2], srd[1], srdy[1], srd[0], srdy[0]};

  split_track #(
    .N_SLAVES (N),
    .DATA_W   (32),
    .ADDR_W   (32),
    .TIMEOUT  (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_resp (m_resp),
    .s_req  (s_req),
    .s_resp (s_resp),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic logic slot_valid(input int k);
    return s_req[k*REQ_W + REQ_W - 1];
  endfunction

  function automatic logic [31:0] slot_addr(input int k);
    return s_req[k*REQ_W + REQ_W - 2 -: 32];
  endfunction

  task automatic drive(input logic v, input logic [31:0] a);
    m_req = {v, a, a ^ 32'h5A5A_0000, 4'hF};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: who owns the bus, how long it has waited,
  // and whether a local completion / error pulse is due.
  bit md_busy    = 1'b0;
  bit md_errcyc  = 1'b0;
  bit md_errnext = 1'b0;
  int md_owner   = 0;
  int md_wait    = 0;

  always @(negedge clk) begin : model
    logic [N*REQ_W-1:0] e_sreq;
    logic [RESP_W-1:0]  e_resp;
    logic               e_err;
    logic [31:0]        a;
    int                 tgt;
    e_sreq = '0;
    e_resp = '0;
    e_err  = 1'b0;
    if (!rst) begin
      md_busy = 0; md_errcyc = 0; md_errnext = 0; md_wait = 0;
    end else begin
      e_err      = md_errnext;
      md_errnext = 0;
      if (md_errcyc) begin
        e_resp    = 33'h1;
        md_errcyc = 0;
      end else if (md_busy) begin
        e_sreq[md_owner*REQ_W +: REQ_W] = m_req;
        e_resp = s_resp[md_owner*RESP_W +: RESP_W];
        if (e_resp[0]) md_busy = 0;
        else if (TO_EN && md_wait == TMO) begin
          e_sreq[md_owner*REQ_W + REQ_W - 1] = 1'b0;
          e_resp     = 33'h1;
          md_busy    = 0;
          md_errnext = 1;
        end else md_wait++;
      end else if (m_req[REQ_W-1]) begin
        a   = m_req[REQ_W-2 -: 32];
        tgt = int'(a >> 30);
        if (tgt < N) begin
          e_sreq[tgt*REQ_W +: REQ_W] = m_req;
          e_resp = s_resp[tgt*RESP_W +: RESP_W];
          if (!e_resp[0]) begin
            md_busy = 1; md_owner = tgt; md_wait = 0;
          end
        end else begin
          md_errcyc  = 1;
          md_errnext = 1;
        end
      end
    end
    chk("cyc_sreq", s_req, e_sreq);
    chk("cyc_mresp", m_resp, e_resp);
    chk("cyc_err", err, e_err);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    m_req = '0;
    for (int i = 0; i < 3; i++) begin
      srd[i] = '0; srdy[i] = 1'b0;
    end
    #3;
    chk("rst_sreq", s_req, 0);
    chk("rst_mresp", m_resp, 0);
    chk("rst_err", err, 0);
    step(); step();
    rst = 1'b1;
    step();

    // zero-wait slave 2, then back-to-back zero-wait slave 1
    srdy[2] = 1'b1; srd[2] = 32'hDEAD_BEEF;
    drive(1'b1, 32'h8000_0010); #1;
    chk("t1_s2_valid", slot_valid(2), 1);
    chk("t1_s01_quiet", s_req[2*REQ_W-1:0], 0);
    chk("t1_resp", m_resp, {32'hDEAD_BEEF, 1'b1});
    step();
    srdy[2] = 1'b0; srdy[1] = 1'b1; srd[1] = 32'h0000_1111;
    drive(1'b1, 32'h4000_0004); #1;
    chk("t1_b2b_s1", slot_valid(1), 1);
    chk("t1_b2b_resp", m_resp, {32'h0000_1111, 1'b1});
    step();

    // slave 0 waits; stray readies on slots 1/2; address MSB changes mid-wait
    srdy[1] = 1'b1;
    drive(1'b1, 32'h0000_0020); #1;
    chk("t2_s0_valid", slot_valid(0), 1);
    chk("t2_wait1", m_resp[0], 0);
    step();
    srdy[2] = 1'b1;
    drive(1'b1, 32'h8000_0020); #1;
    chk("t2_stray_ignored", m_resp[0], 0);
    chk("t2_s2_quiet", slot_valid(2), 0);
    chk("t2_s1_quiet", slot_valid(1), 0);
    chk("t2_s0_addr", slot_addr(0), 32'h8000_0020);
    step(); #1;
    chk("t2_wait3", m_resp[0], 0);
    step();
    srdy[0] = 1'b1; srd[0] = 32'hCAFE_0000; #1;
    chk("t2_done", m_resp, {32'hCAFE_0000, 1'b1});
    step();
    drive(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) srdy[i] = 1'b0;
    #1;
    chk("t2_idle_sreq", s_req, 0);

    // unmapped address (top bits 2'b11)
    step();
    drive(1'b1, 32'hC000_0000); #1;
    chk("t3_no_sreq", s_req, 0);
    chk("t3_no_resp", m_resp, 0);
    chk("t3_err_lo", err, 0);
    step(); #1;
    chk("t3_err_resp", m_resp, 33'h1);
    chk("t3_err_hi", err, 1);
    chk("t3_err_sreq", s_req, 0);
    step();
    drive(1'b0, 32'h0); #1;
    chk("t3_err_gone", err, 0);

    // reset while BUSY, then a fresh request to slave 1
    step();
    drive(1'b1, 32'h0000_0040);
    step(); #1;
    chk("t4_busy_s0", slot_valid(0), 1);
    #1 rst = 1'b0;
    #1;
    chk("t4_async_sreq", s_req, 0);
    chk("t4_async_resp", m_resp, 0);
    step();
    drive(1'b0, 32'h0);
    step();
    rst = 1'b1;
    step();
    drive(1'b1, 32'h4000_0100); #1;
    chk("t4_new_s1", slot_valid(1), 1);
    chk("t4_new_s0_quiet", slot_valid(0), 0);
    step();
    srdy[1] = 1'b1; srd[1] = 32'h0BAD_F00D; #1;
    chk("t4_new_done", m_resp, {32'h0BAD_F00D, 1'b1});
    step();
    drive(1'b0, 32'h0); srdy[1] = 1'b0;

`ifdef SPLIT_TIMEOUT_EN
    step();
    drive(1'b1, 32'h8000_0000);
    for (int i = 0; i < TMO; i++) begin
      step(); #1;
      chk("t6_to_wait", m_resp[0], 0);
    end
    step(); #1;
    chk("t6_to_resp", m_resp, 33'h1);
    chk("t6_to_s2_valid", slot_valid(2), 0);
    step();
    drive(1'b0, 32'h0); #1;
    chk("t6_to_err", err, 1);
    step();
    drive(1'b1, 32'h8000_0000);
    for (int i = 0; i < TMO; i++) step();
    step();
    srdy[2] = 1'b1; srd[2] = 32'h5555_AAAA; #1;
    chk("t6_race_resp", m_resp, {32'h5555_AAAA, 1'b1});
    step();
    drive(1'b0, 32'h0); srdy[2] = 1'b0; #1;
    chk("t6_race_no_err", err, 0);
`else
    step();
    drive(1'b1, 32'h8000_0000);
    for (int i = 0; i < 7; i++) begin
      step(); #1;
      chk("t6_wait_forever", m_resp[0], 0);
    end
    step();
    srdy[2] = 1'b1; srd[2] = 32'h5555_AAAA; #1;
    chk("t6_late_resp", m_resp, {32'h5555_AAAA, 1'b1});
    step();
    drive(1'b0, 32'h0); srdy[2] = 1'b0; #1;
    chk("t6_no_err", err, 0);
`endif

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
